wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back end of the MEM/WB interface.
- Consumes the MEM/WB register bundle: load data, PC+4 sum, ALU result, 2-bit RF source select, write enable, rd.
- Selects the write-back value, commits it to the 32-entry integer register file and serves the two decode-stage read ports, with write-to-read bypass.
- Also keeps a retired-write counter and a sticky illegal-select flag for debug.

Parameters:
- XLEN, 32, data width of registers and all data ports
- NREG, 32, number of architectural registers (address width = clog2(NREG))
- BYPASS, 1, 1 = same-cycle write data is forwarded to read ports; 0 = reads return the pre-write value

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset
- wb_load_data  in  XLEN  data returned by the load unit
- wb_sum_out  in  XLEN  PC+4 (link value for JAL/JALR)
- wb_result  in  XLEN  ALU result
- wb_control_rf  in  2  write-back source select
- wb_we  in  1  register write enable
- wb_rd  in  5  destination register
- rs1_addr  in  5  read port 1 address
- rs2_addr  in  5  read port 2 address
- rs1_data  out  XLEN  read port 1 data (combinational)
- rs2_data  out  XLEN  read port 2 data (combinational)
- wb_data  out  XLEN  selected write-back value, for forwarding into EX (combinational)
- wb_fwd_valid  out  1  wb_we && wb_rd != 0 && select legal
- retire_cnt  out  32  count of committed register writes
- sel_err  out  1  sticky: illegal select seen with wb_we=1

Behaviour:
- Reset rst is synchronous, active-high.
  - On a posedge with rst=1: all NREG registers become 0, retire_cnt=0, sel_err=0.
  - Any write presented in the same cycle is discarded.
  - Reset mid-stream takes priority over every other event.
- Source select, combinational:
  - 00 → wb_result
  - 01 → wb_load_data
  - 10 → wb_sum_out
  - 11 → illegal; wb_data=0
- Commit, at posedge with rst=0:
  - if wb_we && wb_rd!=0 && wb_control_rf!=11, then regs[wb_rd] <= wb_data and retire_cnt <= retire_cnt+1.
  - retire_cnt wraps 0xFFFFFFFF → 0 silently.
- Illegal select:
  - wb_we=1 with wb_control_rf=11 → no register write, no count; sel_err <= 1 and stays set until rst.
  - wb_we=0 with select 11 is ignored and does not set sel_err.
- x0:
  - writes to rd=0 are dropped, not counted, and do not set any flag.
  - Reads of address 0 always return 0, including through bypass.
- Reads, combinational from the array:
  - BYPASS=1: if rsN_addr == wb_rd, wb_fwd_valid=1 and rsN_addr!=0, then rsN_data = wb_data (write-first).
  - BYPASS=0: rsN_data is the array value; the new value is visible from the cycle after the posedge.
- Both read ports may address the same register or wb_rd simultaneously; each resolves independently with identical results.
- Latency:
  - write visible on the array one posedge after presentation;
  - visible on reads in the same cycle via bypass (BYPASS=1).
- The inputs are driven from a negedge-updated pipeline register, so they are stable for the half cycle preceding each posedge. The block adds no extra pipeline stage.

Decomposition:
- Shared package (riscv_pkg), constants:
  - RF_SRC_ALU=2'b00, RF_SRC_LOAD=2'b01, RF_SRC_PC4=2'b10, RF_SRC_ILL=2'b11
  - REG_ZERO=5'd0
  - XLEN
- One natural sub-module, wb_src_mux: the combinational 4:1 select plus legality decode, producing wb_data and the legal flag.
- Array, bypass, counter and flag stay in wb_regfile.

Test Plan:
- Reset sweep: preload x1..x31 with 0xA5A5_0000+i, assert rst one cycle → every read returns 0, retire_cnt=0, sel_err=0; write presented during rst is not committed.
- Source select: rd=5, we=1, with result=0x11, load=0x22, sum=0x33, select 00/01/10 over three cycles → x5 reads 0x11, then 0x22, then 0x33; retire_cnt=3.
- x0 protection: we=1, rd=0, result=0xDEADBEEF → rs1_addr=0 reads 0 in the same cycle and the next; retire_cnt unchanged; wb_fwd_valid=0.
- Bypass: BYPASS=1, x7=0x100, present we=1 rd=7 result=0x200, rs1=rs2=7 → both read 0x200 before the edge. With BYPASS=0 the same stimulus → 0x100 before the edge, 0x200 after.
- Illegal select: we=1, select 11, rd=9 → x9 unchanged, retire_cnt unchanged, sel_err=1 and still 1 after 10 idle cycles; cleared only by rst. Select 11 with we=0 → sel_err stays 0.
- Counter wrap: force retire_cnt to 0xFFFF_FFFF, commit one write to x3 → retire_cnt=0 and x3 updated.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V pipeline constants for the write-back stage
package riscv_pkg;

  localparam int XLEN = 32;

  // Write-back source select encoding carried in the MEM/WB bundle
  typedef enum logic [1:0] {
    RF_SRC_ALU  = 2'b00,
    RF_SRC_LOAD = 2'b01,
    RF_SRC_PC4  = 2'b10,
    RF_SRC_ILL  = 2'b11
  } rf_src_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : riscv_pkg

// File: rtl/wb_src_mux.sv
// rtl/wb_src_mux.sv - write-back source select and legality decode
module wb_src_mux
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [1:0]      sel_i,
  input  logic [XLEN-1:0] result_i,
  input  logic [XLEN-1:0] load_data_i,
  input  logic [XLEN-1:0] sum_out_i,
  output logic [XLEN-1:0] data_o,
  output logic            legal_o
);

  // Pick the write-back value; the reserved encoding yields zero and is flagged illegal
  always_comb begin
    data_o  = '0;
    legal_o = 1'b1;
    case (rf_src_e'(sel_i))
      RF_SRC_ALU:  data_o = result_i;
      RF_SRC_LOAD: data_o = load_data_i;
      RF_SRC_PC4:  data_o = sum_out_i;
      default: begin
        data_o  = '0;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule : wb_src_mux

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB write-back, integer register file and decode read ports
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] wb_load_data,
  input  logic [XLEN-1:0] wb_sum_out,
  input  logic [XLEN-1:0] wb_result,
  input  logic [1:0]      wb_control_rf,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_fwd_valid,
  output logic [31:0]     retire_cnt,
  output logic            sel_err
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [31:0]     retire_cnt_q, retire_cnt_d;
  logic            sel_err_q, sel_err_d;
  logic            src_legal;
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   rs1_idx;
  logic [AW-1:0]   rs2_idx;

  assign rd_idx  = wb_rd[AW-1:0];
  assign rs1_idx = rs1_addr[AW-1:0];
  assign rs2_idx = rs2_addr[AW-1:0];

  wb_src_mux #(
    .XLEN (XLEN)
  ) u_src_mux (
    .sel_i       (wb_control_rf),
    .result_i    (wb_result),
    .load_data_i (wb_load_data),
    .sum_out_i   (wb_sum_out),
    .data_o      (wb_data),
    .legal_o     (src_legal)
  );

  // A write commits only when enabled, legal and not aimed at x0
  assign wb_fwd_valid = wb_we && (wb_rd != REG_ZERO) && src_legal;

  // Next-state for the debug counter and the sticky illegal-select flag
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    sel_err_d    = sel_err_q;
    if (wb_fwd_valid) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
    if (wb_we && !src_legal) begin
      sel_err_d = 1'b1;
    end
  end

  // Register array commit; reset clears every entry and discards any pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_fwd_valid) begin
      regs_q[rd_idx] <= wb_data;
    end
  end

  // Debug state update
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
      sel_err_q    <= 1'b0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign sel_err    = sel_err_q;

  // Read port 1: x0 hardwired to zero, optional write-first forwarding of the pending write
  always_comb begin
    rs1_data = regs_q[rs1_idx];
    if (rs1_addr == REG_ZERO) begin
      rs1_data = '0;
    end else if ((BYPASS != 0) && wb_fwd_valid && (rs1_addr == wb_rd)) begin
      rs1_data = wb_data;
    end
  end

  // Read port 2: resolves identically to port 1
  always_comb begin
    rs2_data = regs_q[rs2_idx];
    if (rs2_addr == REG_ZERO) begin
      rs2_data = '0;
    end else if ((BYPASS != 0) && wb_fwd_valid && (rs2_addr == wb_rd)) begin
      rs2_data = wb_data;
    end
  end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile against a behavioural register model
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] wb_load_data;
  logic [31:0] wb_sum_out;
  logic [31:0] wb_result;
  logic [1:0]  wb_control_rf;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;

  logic [31:0] rs1_b, rs2_b, wbd_b, cnt_b;
  logic        fwd_b, err_b;
  logic [31:0] rs1_n, rs2_n, wbd_n, cnt_n;
  logic        fwd_n, err_n;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_regs [32];
  logic [31:0] ref_cnt;
  logic        ref_err;

  wb_regfile #(.XLEN(32), .NREG(32), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst),
    .wb_load_data(wb_load_data), .wb_sum_out(wb_sum_out), .wb_result(wb_result),
    .wb_control_rf(wb_control_rf), .wb_we(wb_we), .wb_rd(wb_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_b), .rs2_data(rs2_b), .wb_data(wbd_b),
    .wb_fwd_valid(fwd_b), .retire_cnt(cnt_b), .sel_err(err_b)
  );

  wb_regfile #(.XLEN(32), .NREG(32), .BYPASS(0)) u_nbyp (
    .clk(clk), .rst(rst),
    .wb_load_data(wb_load_data), .wb_sum_out(wb_sum_out), .wb_result(wb_result),
    .wb_control_rf(wb_control_rf), .wb_we(wb_we), .wb_rd(wb_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_n), .rs2_data(rs2_n), .wb_data(wbd_n),
    .wb_fwd_valid(fwd_n), .retire_cnt(cnt_n), .sel_err(err_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_wb();
    case (wb_control_rf)
      2'd0:    return wb_result;
      2'd1:    return wb_load_data;
      2'd2:    return wb_sum_out;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_commit();
    return wb_we && (wb_rd != 5'd0) && (wb_control_rf != 2'd3);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && exp_commit() && a == wb_rd) return exp_wb();
    return ref_regs[a];
  endfunction

  task automatic set_in(input logic r, input logic we, input logic [1:0] sel, input logic [4:0] rd,
                        input logic [31:0] res, input logic [31:0] ld, input logic [31:0] sum,
                        input logic [4:0] a1, input logic [4:0] a2);
    rst = r; wb_we = we; wb_control_rf = sel; wb_rd = rd;
    wb_result = res; wb_load_data = ld; wb_sum_out = sum;
    rs1_addr = a1; rs2_addr = a2;
  endtask

  task automatic idle_in(input logic [4:0] a1, input logic [4:0] a2);
    set_in(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, a1, a2);
  endtask

  // Check every output against the model just before the edge, then advance one cycle
  task automatic step();
    #1;
    check("rs1_byp",  rs1_b, exp_read(rs1_addr, 1'b1));
    check("rs2_byp",  rs2_b, exp_read(rs2_addr, 1'b1));
    check("rs1_nbyp", rs1_n, exp_read(rs1_addr, 1'b0));
    check("rs2_nbyp", rs2_n, exp_read(rs2_addr, 1'b0));
    check("wb_data",  wbd_b, exp_wb());
    check("wb_fwd",   {31'd0, fwd_b}, {31'd0, exp_commit()});
    check("cnt_byp",  cnt_b, ref_cnt);
    check("cnt_nbyp", cnt_n, ref_cnt);
    check("err_byp",  {31'd0, err_b}, {31'd0, ref_err});
    check("err_nbyp", {31'd0, err_n}, {31'd0, ref_err});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
      ref_cnt = 32'd0;
      ref_err = 1'b0;
    end else begin
      if (exp_commit()) begin
        ref_regs[wb_rd] = exp_wb();
        ref_cnt = ref_cnt + 32'd1;
      end
      if (wb_we && wb_control_rf == 2'd3) ref_err = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    ref_cnt = 32'd0;
    ref_err = 1'b0;
    set_in(1'b1, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_cnt", cnt_b, 32'd0);
    check("reset_err", {31'd0, err_b}, 32'd0);

    // Reset sweep: preload, reset with a write pending, then read everything back
    for (int i = 1; i < 32; i++) begin
      set_in(1'b0, 1'b1, 2'd0, 5'(i), 32'hA5A5_0000 + i, 32'h0, 32'h0, 5'(i), 5'd0);
      step();
    end
    check("preload_cnt", cnt_b, 32'd31);
    set_in(1'b1, 1'b1, 2'd0, 5'd4, 32'h1234_5678, 32'h0, 32'h0, 5'd4, 5'd9);
    step();
    for (int i = 0; i < 32; i++) begin
      idle_in(5'(i), 5'(31 - i));
      #1;
      check("sweep_rs1", rs1_n, 32'd0);
      step();
    end

    // Source select onto x5
    set_in(1'b0, 1'b1, 2'd0, 5'd5, 32'h11, 32'h22, 32'h33, 5'd5, 5'd5); step();
    idle_in(5'd5, 5'd0); #1; check("sel_alu", rs1_n, 32'h11);
    set_in(1'b0, 1'b1, 2'd1, 5'd5, 32'h11, 32'h22, 32'h33, 5'd5, 5'd5); step();
    idle_in(5'd5, 5'd0); #1; check("sel_load", rs1_n, 32'h22);
    set_in(1'b0, 1'b1, 2'd2, 5'd5, 32'h11, 32'h22, 32'h33, 5'd5, 5'd5); step();
    idle_in(5'd5, 5'd0); #1; check("sel_pc4", rs1_n, 32'h33);
    check("sel_cnt", cnt_b, 32'd3);

    // x0 protection
    set_in(1'b0, 1'b1, 2'd0, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 5'd0);
    #1;
    check("x0_same", rs1_b, 32'd0);
    check("x0_fwd", {31'd0, fwd_b}, 32'd0);
    step();
    idle_in(5'd0, 5'd0); #1;
    check("x0_next", rs1_b, 32'd0);
    check("x0_cnt", cnt_b, 32'd3);

    // Bypass versus no bypass on x7
    set_in(1'b0, 1'b1, 2'd0, 5'd7, 32'h100, 32'h0, 32'h0, 5'd0, 5'd0); step();
    set_in(1'b0, 1'b1, 2'd0, 5'd7, 32'h200, 32'h0, 32'h0, 5'd7, 5'd7);
    #1;
    check("byp_rs1", rs1_b, 32'h200);
    check("byp_rs2", rs2_b, 32'h200);
    check("nbyp_rs1_pre", rs1_n, 32'h100);
    check("nbyp_rs2_pre", rs2_n, 32'h100);
    step();
    idle_in(5'd7, 5'd7); #1;
    check("nbyp_rs1_post", rs1_n, 32'h200);

    // Illegal select: select 11 with we=0 leaves the flag clear
    set_in(1'b0, 1'b0, 2'd3, 5'd9, 32'h9999, 32'h0, 32'h0, 5'd9, 5'd0); step();
    #1; check("ill_we0", {31'd0, err_b}, 32'd0);
    set_in(1'b0, 1'b1, 2'd3, 5'd9, 32'h9999, 32'h9999, 32'h9999, 5'd9, 5'd0); step();
    for (int i = 0; i < 10; i++) begin idle_in(5'd9, 5'd9); step(); end
    #1;
    check("ill_sticky", {31'd0, err_b}, 32'd1);
    check("ill_x9", rs1_n, 32'd0);
    set_in(1'b1, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0); step();
    #1; check("ill_clear", {31'd0, err_b}, 32'd0);

    // Counter wrap
    force u_byp.retire_cnt_q  = 32'hFFFF_FFFF;
    force u_nbyp.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release u_byp.retire_cnt_q;
    release u_nbyp.retire_cnt_q;
    ref_cnt = 32'hFFFF_FFFF;
    set_in(1'b0, 1'b1, 2'd1, 5'd3, 32'h0, 32'h0BAD_F00D, 32'h0, 5'd3, 5'd3); step();
    idle_in(5'd3, 5'd3); #1;
    check("wrap_cnt", cnt_b, 32'd0);
    check("wrap_x3", rs1_n, 32'h0BAD_F00D);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      logic [4:0] rd;
      logic [4:0] a1;
      logic [4:0] a2;
      rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      set_in(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
             rd, $urandom, $urandom, $urandom, a1, a2);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_wb_regfile
